hilo_muldiv_seq: RTL and testbench

// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO write path of the register file.

---
 rtl/hilo_muldiv_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_seq
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO
//            write path. A shift-add multiplier or a restoring divider works
//            on operand magnitudes for WIDTH/BITS_PER_CYCLE cycles. A single
//            fix-up cycle then applies the result signs, and hi_we/lo_we pulse
//            for one cycle with the 2*WIDTH-bit result.
// Ports    : clk, rst     - clock (rising edge), asynchronous active-high reset
//            start, op    - new request and its opcode
//                           (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//            rs_val       - multiplicand / dividend
//            rt_val       - multiplier / divisor
//            hilo_rd      - current instruction reads HI/LO (MFHI/MFLO)
//            flush        - cancel the operation in flight
//            busy, stall  - operation in flight / core must hold its instruction
//            hi_we, lo_we - HI/LO write strobes (DONE cycle only)
//            hi_res       - product upper half / remainder
//            lo_res       - product lower half / quotient
//            div_zero     - divisor was zero (pulses with the strobes)
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             div_zero
);

    localparam int c_ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int c_CNT_W = (c_ITERS > 1) ? $clog2(c_ITERS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITERS - 1);
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_ONE2     = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_lo;   // negate product (mul) / quotient (div)
    logic               r_neg_hi;   // negate remainder (div only)
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;       // accumulator / partial remainder
    logic [WIDTH-1:0]   r_lo;       // multiplier / dividend, shifted each step
    logic [WIDTH-1:0]   r_d;        // multiplicand / divisor magnitude

    // ------------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------------
    logic             w_is_div;
    logic             w_signed;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic             w_accept;
    logic             w_dz;

    assign w_is_div = op[1];
    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & rs_val[WIDTH-1];
    assign w_rt_neg = w_signed & rt_val[WIDTH-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    assign w_rs_mag = w_rs_neg ? (~rs_val + c_ONE) : rs_val;
    assign w_rt_mag = w_rt_neg ? (~rt_val + c_ONE) : rt_val;
    // flush wins over a start arriving in IDLE.
    assign w_accept = (r_state == S_IDLE) & start & ~flush;
    assign w_dz     = w_is_div & (rt_val == '0);

    // ------------------------------------------------------------------------
    // One CALC cycle: BITS_PER_CYCLE unrolled radix-2 steps
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        w_rem     = '0;
        w_sum     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_is_div) begin
                // Restoring divide: shift the next dividend bit into the
                // remainder; subtract only when it does not go negative.
                w_rem     = {w_step_hi, w_step_lo[WIDTH-1]};
                w_step_lo = {w_step_lo[WIDTH-2:0], 1'b0};
                if (w_rem >= {1'b0, r_d}) begin
                    w_rem        = w_rem - {1'b0, r_d};
                    w_step_lo[0] = 1'b1;
                end
                w_step_hi = w_rem[WIDTH-1:0];
            end else begin
                // Shift-add multiply: conditionally add, then shift the
                // {carry, hi, lo} chain right by one.
                w_sum     = {1'b0, w_step_hi} + (w_step_lo[0] ? {1'b0, r_d} : '0);
                w_step_lo = {w_sum[0], w_step_lo[WIDTH-1:1]};
                w_step_hi = w_sum[WIDTH:1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sign fix-up values
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_hi_neg;
    logic [WIDTH-1:0]   w_lo_neg;

    assign w_prod_neg = ~{r_hi, r_lo} + c_ONE2;
    assign w_hi_neg   = ~r_hi + c_ONE;
    assign w_lo_neg   = ~r_lo + c_ONE;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_dz ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_d      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= w_is_div;
                        r_cnt    <= c_CNT_LAST;
                        r_neg_lo <= w_rs_neg ^ w_rt_neg;
                        r_neg_hi <= w_is_div ? w_rs_neg : (w_rs_neg ^ w_rt_neg);
                        if (w_dz) begin
                            // Result is produced directly; no iteration.
                            r_dz <= 1'b1;
                            r_hi <= rs_val;
                            r_lo <= '1;
                        end else begin
                            r_dz <= 1'b0;
                            r_hi <= '0;
                            r_lo <= w_is_div ? w_rs_mag : w_rt_mag;
                            r_d  <= w_is_div ? w_rt_mag : w_rs_mag;
                        end
                    end
                end
                S_CALC: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        if (r_neg_lo) begin
                            {r_hi, r_lo} <= w_prod_neg;
                        end
                    end else begin
                        if (r_neg_lo) begin
                            r_lo <= w_lo_neg;
                        end
                        if (r_neg_hi) begin
                            r_hi <= w_hi_neg;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from state so asynchronous reset clears them at once)
    // ------------------------------------------------------------------------
    logic w_in_done;
    assign w_in_done = (r_state == S_DONE);

    assign busy     = (r_state != S_IDLE);
    assign stall    = (start | hilo_rd) & busy;
    assign hi_we    = w_in_done & ~flush;
    assign lo_we    = w_in_done & ~flush;
    assign div_zero = w_in_done & ~flush & r_dz;
    assign hi_res   = w_in_done ? r_hi : '0;
    assign lo_res   = w_in_done ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_seq
// Purpose  : Directed self-checking bench for hilo_muldiv_seq. Two instances:
//            u_dut (1 bit per cycle) and u_dut4 (4 bits per cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start4;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_rd;
    logic        flush;

    logic        busy, stall, hi_we, lo_we, div_zero;
    logic [31:0] hi_res, lo_res;
    logic        busy4, stall4, hi_we4, lo_we4, div_zero4;
    logic [31:0] hi_res4, lo_res4;

    int n_cmp;
    int n_err;

    localparam logic [1:0] c_MULT  = 2'b00;
    localparam logic [1:0] c_MULTU = 2'b01;
    localparam logic [1:0] c_DIV   = 2'b10;
    localparam logic [1:0] c_DIVU  = 2'b11;

    hilo_muldiv_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .hilo_rd(hilo_rd), .flush(flush), .busy(busy),
        .stall(stall), .hi_we(hi_we), .lo_we(lo_we), .hi_res(hi_res),
        .lo_res(lo_res), .div_zero(div_zero)
    );

    hilo_muldiv_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .hilo_rd(hilo_rd), .flush(flush), .busy(busy4),
        .stall(stall4), .hi_we(hi_we4), .lo_we(lo_we4), .hi_res(hi_res4),
        .lo_res(lo_res4), .div_zero(div_zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drive a request so that the next rising edge accepts it (DUT must be idle).
    task automatic accept(input logic sel4, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op     = o;
        rs_val = a;
        rt_val = b;
        if (sel4) start4 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    // Run one op; cycle k counts from the accepting edge (k=1 is the first
    // cycle after it). Reports strobe cycle, results and first idle cycle.
    task automatic run_op(input logic sel4, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] h,
                          output logic [31:0] l, output logic dz,
                          output int nstrobe, output int idle_at);
        logic w, bz;
        lat = -1; h = '0; l = '0; dz = 1'b0; nstrobe = 0; idle_at = -1;
        accept(sel4, o, a, b);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            w  = sel4 ? hi_we4 : hi_we;
            bz = sel4 ? busy4  : busy;
            if (w) begin
                nstrobe++;
                if (lat < 0) begin
                    lat = k;
                    h   = sel4 ? hi_res4   : hi_res;
                    l   = sel4 ? lo_res4   : lo_res;
                    dz  = sel4 ? div_zero4 : div_zero;
                end
            end
            if (!bz && idle_at < 0) idle_at = k;
            if (idle_at >= 0 && k > idle_at + 2) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; start4 = 0; op = 0; rs_val = 0; rt_val = 0;
        hilo_rd = 0; flush = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_cmp++; if ({hi_we, lo_we, div_zero} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b expected 000", {hi_we, lo_we, div_zero}); end
        n_cmp++; if ({hi_res, lo_res} !== 64'h0) begin n_err++; $display("FAIL reset_res: got %h expected 0", {hi_res, lo_res}); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
    endtask

    // Single-op scenarios; each row: op, rs, rt, exp hi, exp lo, exp div_zero, exp latency
    task automatic test_ops();
        logic [1:0]  t_op [9];
        logic [31:0] t_a [9], t_b [9], t_h [9], t_l [9];
        logic        t_dz [9];
        int          t_lat [9];
        int lat, ns, idle;
        logic [31:0] h, l;
        logic dz;
        t_op[0]=c_MULTU; t_a[0]=32'hFFFFFFFF; t_b[0]=32'hFFFFFFFF; t_h[0]=32'hFFFFFFFE; t_l[0]=32'h00000001; t_dz[0]=0; t_lat[0]=34;
        t_op[1]=c_MULT;  t_a[1]=32'hFFFFFFFD; t_b[1]=32'd7;        t_h[1]=32'hFFFFFFFF; t_l[1]=32'hFFFFFFEB; t_dz[1]=0; t_lat[1]=34;
        t_op[2]=c_MULTU; t_a[2]=32'h12345678; t_b[2]=32'h10;       t_h[2]=32'h00000001; t_l[2]=32'h23456780; t_dz[2]=0; t_lat[2]=34;
        t_op[3]=c_MULT;  t_a[3]=32'h80000000; t_b[3]=32'd2;        t_h[3]=32'hFFFFFFFF; t_l[3]=32'h00000000; t_dz[3]=0; t_lat[3]=34;
        t_op[4]=c_DIV;   t_a[4]=32'hFFFFFFF9; t_b[4]=32'd2;        t_h[4]=32'hFFFFFFFF; t_l[4]=32'hFFFFFFFD; t_dz[4]=0; t_lat[4]=34;
        t_op[5]=c_DIVU;  t_a[5]=32'd100;      t_b[5]=32'd7;        t_h[5]=32'd2;        t_l[5]=32'd14;       t_dz[5]=0; t_lat[5]=34;
        t_op[6]=c_DIV;   t_a[6]=32'd7;        t_b[6]=32'hFFFFFFFE; t_h[6]=32'd1;        t_l[6]=32'hFFFFFFFD; t_dz[6]=0; t_lat[6]=34;
        t_op[7]=c_DIV;   t_a[7]=32'h80000000; t_b[7]=32'hFFFFFFFF; t_h[7]=32'h00000000; t_l[7]=32'h80000000; t_dz[7]=0; t_lat[7]=34;
        // Divide by zero goes straight to DONE in the first cycle after acceptance.
        t_op[8]=c_DIVU;  t_a[8]=32'd100;      t_b[8]=32'd0;        t_h[8]=32'd100;      t_l[8]=32'hFFFFFFFF; t_dz[8]=1; t_lat[8]=1;
        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, t_op[i], t_a[i], t_b[i], lat, h, l, dz, ns, idle);
            n_cmp++; if (lat !== t_lat[i]) begin n_err++; $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, t_lat[i]); end
            n_cmp++; if (h !== t_h[i]) begin n_err++; $display("FAIL op%0d_hi: got %h expected %h", i, h, t_h[i]); end
            n_cmp++; if (l !== t_l[i]) begin n_err++; $display("FAIL op%0d_lo: got %h expected %h", i, l, t_l[i]); end
            n_cmp++; if (dz !== t_dz[i]) begin n_err++; $display("FAIL op%0d_div_zero: got %b expected %b", i, dz, t_dz[i]); end
            n_cmp++; if (ns !== 1) begin n_err++; $display("FAIL op%0d_strobe_count: got %0d expected 1", i, ns); end
            n_cmp++; if (idle !== t_lat[i] + 1) begin n_err++; $display("FAIL op%0d_busy_end: got %0d expected %0d", i, idle, t_lat[i] + 1); end
        end
        // Signed divide by zero reports the raw dividend.
        run_op(1'b0, c_DIV, 32'hFFFFFFFB, 32'd0, lat, h, l, dz, ns, idle);
        n_cmp++; if ({lat, h, l, dz} !== {32'd1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1}) begin
            n_err++; $display("FAIL div_zero_signed: got lat=%0d hi=%h lo=%h dz=%b expected lat=1 hi=fffffffb lo=ffffffff dz=1", lat, h, l, dz);
        end
    endtask

    task automatic test_back_to_back();
        int stall_bad, s1, s2;
        logic [31:0] h1, l1, h2, l2;
        logic b36;
        stall_bad = 0; s1 = -1; s2 = -1; h1 = 0; l1 = 0; h2 = 0; l2 = 0; b36 = 0;
        accept(1'b0, c_MULTU, 32'd5, 32'd6);
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (k == 5) begin op = c_DIVU; rs_val = 32'd50; rt_val = 32'd7; end
            start   = (k >= 5 && k <= 35);
            hilo_rd = (k >= 10 && k <= 34);
            #1;
            if (stall !== (k >= 5 && k <= 34)) begin
                stall_bad++;
                $display("FAIL b2b_stall_cycle%0d: got %b expected %b", k, stall, (k >= 5 && k <= 34));
            end
            if (k == 36) b36 = busy;
            if (hi_we === 1'b1) begin
                if (s1 < 0) begin s1 = k; h1 = hi_res; l1 = lo_res; end
                else if (s2 < 0) begin s2 = k; h2 = hi_res; l2 = lo_res; end
            end
        end
        start = 1'b0; hilo_rd = 1'b0;
        n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL b2b_stall: got %0d bad cycles expected 0", stall_bad); end
        n_cmp++; if (s1 !== 34) begin n_err++; $display("FAIL b2b_first_strobe: got %0d expected 34", s1); end
        n_cmp++; if ({h1, l1} !== {32'd0, 32'd30}) begin n_err++; $display("FAIL b2b_first_result: got %h expected %h", {h1, l1}, {32'd0, 32'd30}); end
        n_cmp++; if (b36 !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: busy got %b expected 1", b36); end
        n_cmp++; if (s2 !== 69) begin n_err++; $display("FAIL b2b_second_strobe: got %0d expected 69", s2); end
        n_cmp++; if ({h2, l2} !== {32'd1, 32'd7}) begin n_err++; $display("FAIL b2b_second_result: got %h expected %h", {h2, l2}, {32'd1, 32'd7}); end
    endtask

    task automatic test_flush();
        int ns, lat, idle;
        logic b20, b21, w34, w34f;
        logic [31:0] h, l;
        logic dz;
        ns = 0; b20 = 0; b21 = 1; w34 = 0; w34f = 1;
        accept(1'b0, c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 20) begin b20 = busy; flush = 1'b1; end
            if (k == 21) begin b21 = busy; flush = 1'b0; end
            if (hi_we === 1'b1 || lo_we === 1'b1) ns++;
        end
        n_cmp++; if ({b20, b21} !== 2'b10) begin n_err++; $display("FAIL flush_calc_busy: got %b expected 10", {b20, b21}); end
        n_cmp++; if (ns !== 0) begin n_err++; $display("FAIL flush_calc_strobes: got %0d expected 0", ns); end
        // flush together with start in IDLE: start is ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = c_MULTU; rs_val = 32'd3; rt_val = 32'd3;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_idle: busy got %b expected 0", busy); end
        // a new op after a flush completes normally
        run_op(1'b0, c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, h, l, dz, ns, idle);
        n_cmp++; if ({lat, h, l} !== {32'd34, 32'hFFFFFFFE, 32'h00000001}) begin
            n_err++; $display("FAIL flush_then_op: got lat=%0d hi=%h lo=%h expected lat=34 hi=fffffffe lo=00000001", lat, h, l);
        end
        // flush during DONE suppresses the strobes in that same cycle
        accept(1'b0, c_MULTU, 32'd2, 32'd2);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 34) begin
                w34 = hi_we;
                flush = 1'b1;
                #1;
                w34f = hi_we | lo_we;
            end
        end
        @(negedge clk); flush = 1'b0;
        n_cmp++; if (w34 !== 1'b1) begin n_err++; $display("FAIL done_strobe_before_flush: got %b expected 1", w34); end
        n_cmp++; if (w34f !== 1'b0) begin n_err++; $display("FAIL flush_done_strobes: got %b expected 0", w34f); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_done_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        logic s_pre, b_post, s_post, w_post;
        int ns, bz;
        ns = 0; bz = 0;
        accept(1'b0, c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (15) @(negedge clk);
        hilo_rd = 1'b1;
        #1 s_pre = stall;
        #3 rst = 1'b1;
        #1;
        b_post = busy; s_post = stall; w_post = hi_we | lo_we;
        hilo_rd = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (hi_we === 1'b1 || lo_we === 1'b1) ns++;
            if (busy !== 1'b0) bz++;
        end
        n_cmp++; if (s_pre !== 1'b1) begin n_err++; $display("FAIL areset_stall_before: got %b expected 1", s_pre); end
        n_cmp++; if ({b_post, s_post, w_post} !== 3'b000) begin n_err++; $display("FAIL areset_immediate: got %b expected 000", {b_post, s_post, w_post}); end
        n_cmp++; if (ns !== 0) begin n_err++; $display("FAIL areset_no_write: got %0d strobes expected 0", ns); end
        n_cmp++; if (bz !== 0) begin n_err++; $display("FAIL areset_stays_idle: got %0d busy cycles expected 0", bz); end
    endtask

    task automatic test_radix4();
        int lat, ns, idle;
        logic [31:0] h, l;
        logic dz;
        run_op(1'b1, c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, h, l, dz, ns, idle);
        n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL r4_mul_latency: got %0d expected 10", lat); end
        n_cmp++; if ({h, l} !== {32'hFFFFFFFE, 32'h00000001}) begin n_err++; $display("FAIL r4_mul_result: got %h expected fffffffe00000001", {h, l}); end
        run_op(1'b1, c_DIV, 32'hFFFFFFF9, 32'd2, lat, h, l, dz, ns, idle);
        n_cmp++; if ({lat, h, l} !== {32'd10, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            n_err++; $display("FAIL r4_div: got lat=%0d hi=%h lo=%h expected lat=10 hi=ffffffff lo=fffffffd", lat, h, l);
        end
        n_cmp++; if (idle !== 11) begin n_err++; $display("FAIL r4_busy_end: got %0d expected 11", idle); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ops();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_radix4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
